// File: rtl/serial_pkg.sv
// serial_pkg: shared definitions for the 4-bit serial link.
//   DATA_W     payload bits per frame
//   FRAME_LEN  start + data + stop bits
//   START_BIT / STOP_BIT line levels for the framing bits
//   tx_state_t transmitter state encoding
// Imported by the transmit arbiter and by the link receiver.
package serial_pkg;

   localparam int   DATA_W    = 4;
   localparam int   FRAME_LEN = 6;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      GAP   = 3'd4
   } tx_state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational winner selection among NUM_REQ requesters.
//   req        level requests, one bit per requester
//   last_grant index granted most recently (round-robin build only)
//   winner     one-hot winner, all zero when no request
//   winner_id  binary index of the winner
//   any        at least one request is pending
// Build option SERIAL_ARB_FIXED_PRIO_EN: when defined, the lowest asserted
// index always wins and the last_grant port does not exist.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
`ifndef SERIAL_ARB_FIXED_PRIO_EN
   input  logic [IDX_W-1:0]   last_grant,
`endif
   output logic [NUM_REQ-1:0] winner,
   output logic [IDX_W-1:0]   winner_id,
   output logic               any
);

`ifdef SERIAL_ARB_FIXED_PRIO_EN

   always_comb begin
      winner    = '0;
      winner_id = '0;
      any       = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!any && req[i]) begin
            any       = 1'b1;
            winner[i] = 1'b1;
            winner_id = IDX_W'(i);
         end
      end
   end

`else

   // Search order is last_grant+1, last_grant+2, ... wrapping modulo
   // NUM_REQ, so the previous winner is considered last.
   always_comb begin
      int               idx;
      logic [IDX_W-1:0] idx_l;
      idx       = 0;
      idx_l     = '0;
      winner    = '0;
      winner_id = '0;
      any       = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = int'(last_grant) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         idx_l = IDX_W'(idx);
         if (!any && req[idx_l]) begin
            any           = 1'b1;
            winner[idx_l] = 1'b1;
            winner_id     = idx_l;
         end
      end
   end

`endif

endmodule

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: shares one serial link among NUM_REQ requesters and
// serializes each granted 4-bit payload as start(0), 4 data bits LSB
// first, stop(1), one bit per clock, followed by GAP_CYCLES idle-high
// cycles. Frames are never interleaved or truncated.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   req        level request per requester
//   payload    requester i data in [i*DATA_W +: DATA_W], sampled at grant
//   grant      one-hot, one-cycle capture acknowledge (registered)
//   tx         serial line, idle high (registered)
//   busy       high from the start bit through the last gap cycle
//   cur_id     index of the requester being sent; holds when idle
//   fsm_state  current transmitter state, for observation
//
// Request/grant handshake: req is a level; a requester whose req is high
// when the link becomes free may be selected, its payload is captured on
// that clock edge and grant pulses for exactly the following cycle. There
// is no back-pressure on grant; keeping req high asks for another frame.
//
// Build option SERIAL_ARB_FIXED_PRIO_EN: fixed lowest-index priority in
// place of round-robin; framing and timing are unchanged.
module serial_tx_arbiter
   import serial_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int GAP_CYCLES = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*DATA_W-1:0]   payload,
   output logic [NUM_REQ-1:0]          grant,
   output logic                        tx,
   output logic                        busy,
   output logic [$clog2(NUM_REQ)-1:0]  cur_id,
   output tx_state_t                   fsm_state
);

   localparam int IDX_W = $clog2(NUM_REQ);
   // Value of the gap counter in the final gap cycle.
   localparam logic [3:0] GAP_LAST = 4'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

   tx_state_t            state_q, state_n;
   logic [DATA_W-1:0]    shift_q, shift_n;
   logic [1:0]           bit_cnt_q, bit_cnt_n;
   logic [3:0]           gap_cnt_q, gap_cnt_n;
   logic [NUM_REQ-1:0]   grant_q, grant_n;
   logic [IDX_W-1:0]     cur_id_q, cur_id_n;
   logic                 tx_q, tx_n;
   logic                 busy_q, busy_n;
   logic                 arbitrate;

   logic [NUM_REQ-1:0]   pick_winner;
   logic [IDX_W-1:0]     pick_id;
   logic                 pick_any;

`ifndef SERIAL_ARB_FIXED_PRIO_EN
   logic [IDX_W-1:0]     last_grant_q, last_grant_n;
`endif

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req        (req),
`ifndef SERIAL_ARB_FIXED_PRIO_EN
      .last_grant (last_grant_q),
`endif
      .winner     (pick_winner),
      .winner_id  (pick_id),
      .any        (pick_any)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         gap_cnt_q    <= '0;
         grant_q      <= '0;
         cur_id_q     <= '0;
         tx_q         <= STOP_BIT;
         busy_q       <= 1'b0;
`ifndef SERIAL_ARB_FIXED_PRIO_EN
         last_grant_q <= IDX_W'(NUM_REQ - 1);
`endif
      end else begin
         state_q      <= state_n;
         shift_q      <= shift_n;
         bit_cnt_q    <= bit_cnt_n;
         gap_cnt_q    <= gap_cnt_n;
         grant_q      <= grant_n;
         cur_id_q     <= cur_id_n;
         tx_q         <= tx_n;
         busy_q       <= busy_n;
`ifndef SERIAL_ARB_FIXED_PRIO_EN
         last_grant_q <= last_grant_n;
`endif
      end
   end

   // Next-state logic. The arbitration decision is taken in IDLE and also
   // in the last cycle of each frame (final gap cycle, or the stop bit when
   // there is no gap), so a waiting requester's start bit follows the
   // frame with no idle dwell and the frame period is 6+GAP_CYCLES.
   // Line outputs are decoded from the next state and registered.
   always_comb begin
      state_n      = state_q;
      shift_n      = shift_q;
      bit_cnt_n    = bit_cnt_q;
      gap_cnt_n    = gap_cnt_q;
      grant_n      = '0;
      cur_id_n     = cur_id_q;
      tx_n         = STOP_BIT;
      busy_n       = 1'b0;
      arbitrate    = 1'b0;
`ifndef SERIAL_ARB_FIXED_PRIO_EN
      last_grant_n = last_grant_q;
`endif

      case (state_q)
         IDLE: begin
            arbitrate = 1'b1;
         end
         START: begin
            state_n   = DATA;
            bit_cnt_n = '0;
         end
         DATA: begin
            if (bit_cnt_q == 2'd3) begin
               state_n = STOP;
            end else begin
               shift_n   = shift_q >> 1;
               bit_cnt_n = bit_cnt_q + 2'd1;
            end
         end
         STOP: begin
            if (GAP_CYCLES == 0) begin
               arbitrate = 1'b1;
            end else begin
               state_n   = GAP;
               gap_cnt_n = '0;
            end
         end
         GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               arbitrate = 1'b1;
            end else begin
               gap_cnt_n = gap_cnt_q + 4'd1;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      if (arbitrate) begin
         state_n   = IDLE;
         gap_cnt_n = '0;
         if (pick_any) begin
            state_n  = START;
            grant_n  = pick_winner;
            cur_id_n = pick_id;
            for (int i = 0; i < NUM_REQ; i++) begin
               if (pick_winner[i]) shift_n = payload[i*DATA_W +: DATA_W];
            end
`ifndef SERIAL_ARB_FIXED_PRIO_EN
            last_grant_n = pick_id;
`endif
         end
      end

      case (state_n)
         START:   tx_n = START_BIT;
         DATA:    tx_n = shift_n[0];
         default: tx_n = STOP_BIT;
      endcase
      busy_n = (state_n != IDLE);
   end

   assign grant     = grant_q;
   assign tx        = tx_q;
   assign busy      = busy_q;
   assign cur_id    = cur_id_q;
   assign fsm_state = state_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb_serial_tx_arbiter: directed bench for serial_tx_arbiter.
// Main instance uses NUM_REQ=4, GAP_CYCLES=1; a second instance with
// GAP_CYCLES=0 exercises back-to-back frames. A monitor decodes the line
// like a receiver and checks grants and received payloads against
// expected queues filled by the stimulus.
module tb_serial_tx_arbiter;
   import serial_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [15:0] payload;
   logic [3:0]  grant;
   logic        tx;
   logic        busy;
   logic [1:0]  cur_id;
   tx_state_t   fsm_state;

   logic [3:0]  g0_req;
   logic [15:0] g0_payload;
   logic [3:0]  g0_grant;
   logic        g0_tx;
   logic        g0_busy;
   logic [1:0]  g0_cur_id;
   tx_state_t   g0_fsm_state;

   int total = 0;
   int bad   = 0;
   int cycle = 0;

   logic [1:0] exp_id_q[$];
   logic [3:0] exp_data_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   serial_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .payload   (payload),
      .grant     (grant),
      .tx        (tx),
      .busy      (busy),
      .cur_id    (cur_id),
      .fsm_state (fsm_state)
   );

   serial_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(0)) dut_g0 (
      .clk       (clk),
      .rst       (rst),
      .req       (g0_req),
      .payload   (g0_payload),
      .grant     (g0_grant),
      .tx        (g0_tx),
      .busy      (g0_busy),
      .cur_id    (g0_cur_id),
      .fsm_state (g0_fsm_state)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Wait (bounded) for the next grant pulse on the main instance.
   task automatic wait_grant(output int cyc);
      cyc = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (grant != 4'b0000) begin
            cyc = cycle;
            return;
         end
      end
      check("grant_timeout", 32'd1, 32'd0);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!busy) return;
      end
      check("idle_timeout", 32'd1, 32'd0);
   endtask

   task automatic set_payloads(input logic [3:0] p0, input logic [3:0] p1,
                               input logic [3:0] p2, input logic [3:0] p3);
      payload = {p3, p2, p1, p0};
   endtask

   // Monitor: grant scoreboard and line receiver.
   initial begin
      logic       in_frame;
      int         nbits;
      logic [3:0] rx_data;
      logic [1:0] id;
      logic [3:0] d;
      in_frame = 1'b0;
      nbits    = 0;
      rx_data  = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            in_frame = 1'b0;
            nbits    = 0;
         end else begin
            if (grant != 4'b0000) begin
               if (exp_id_q.size() == 0) begin
                  check("grant_unexpected", 32'(grant), 32'd0);
               end else begin
                  id = exp_id_q.pop_front();
                  check("grant_id", 32'(grant), 32'd1 << id);
                  check("cur_id", 32'(cur_id), 32'(id));
               end
            end
            if (!in_frame) begin
               if (tx == 1'b0) begin
                  in_frame = 1'b1;
                  nbits    = 0;
               end
            end else if (nbits < 4) begin
               rx_data[nbits] = tx;
               nbits++;
            end else begin
               in_frame = 1'b0;
               check("stop_bit", 32'(tx), 32'd1);
               if (exp_data_q.size() == 0) begin
                  check("data_unexpected", 32'(rx_data), 32'hffff_ffff);
               end else begin
                  d = exp_data_q.pop_front();
                  check("rx_data", 32'(rx_data), 32'(d));
               end
            end
         end
      end
   end

   initial begin
      int         stamp[5];
      int         c;
      logic [9:0] tx_seq, busy_seq, gnt_seq;
      logic [13:0] g0_tx_seq, g0_busy_seq, g0_gnt_seq;

      // ---- reset with all requests asserted ----
      rst        = 1'b0;
      req        = 4'b1111;
      set_payloads(4'h1, 4'h2, 4'h3, 4'h4);
      g0_req     = 4'b0000;
      g0_payload = 16'h0000;
      repeat (3) @(negedge clk);
      check("reset_tx", 32'(tx), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_grant", 32'(grant), 32'd0);
      check("reset_cur_id", 32'(cur_id), 32'd0);
      check("reset_state", 32'(fsm_state), 32'(IDLE));
      @(posedge clk); #1;
      req = 4'b0000;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("post_reset_tx", 32'(tx), 32'd1);
      check("post_reset_busy", 32'(busy), 32'd0);

      // ---- full contention: 0,1,2,3,0 seven cycles apart ----
      @(posedge clk); #1;
      set_payloads(4'h1, 4'h2, 4'h3, 4'h4);
      req = 4'b1111;
      exp_id_q   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      exp_data_q = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
      for (int g = 0; g < 5; g++) wait_grant(stamp[g]);
      req = 4'b0000;
      for (int g = 1; g < 5; g++) check("grant_spacing", 32'(stamp[g] - stamp[g-1]), 32'd7);
      wait_idle();

      // ---- single frame, exact line waveform ----
      @(posedge clk); #1;
      set_payloads(4'b1010, 4'h2, 4'h3, 4'h4);
      req = 4'b0001;
      exp_id_q.push_back(2'd0);
      exp_data_q.push_back(4'b1010);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         tx_seq[i]   = tx;
         busy_seq[i] = busy;
         gnt_seq[i]  = grant[0];
         if (i == 1) req = 4'b0000;
      end
      check("single_tx_seq", 32'(tx_seq), 32'(10'b1111101001));
      check("single_busy_seq", 32'(busy_seq), 32'(10'b0011111110));
      check("single_grant_seq", 32'(gnt_seq), 32'(10'b0000000010));

      // ---- wrap-around: 2 granted, then req 1001 gives 3 then 0 ----
      @(posedge clk); #1;
      set_payloads(4'h1, 4'h2, 4'h3, 4'h4);
      req = 4'b0100;
      exp_id_q   = '{2'd2, 2'd3, 2'd0};
      exp_data_q = '{4'h3, 4'h4, 4'h1};
      wait_grant(c);
      req = 4'b1001;
      wait_grant(c);
      wait_grant(c);
      req = 4'b0000;
      wait_idle();

      // ---- reset during second data bit ----
      @(posedge clk); #1;
      set_payloads(4'h1, 4'hD, 4'h3, 4'h4);
      req = 4'b1111;
      exp_id_q.push_back(2'd1);
      wait_grant(c);
      @(negedge clk);
      @(negedge clk);
      check("tx_second_bit", 32'(tx), 32'd0);
      #1 rst = 1'b0;
      #1;
      check("async_reset_tx", 32'(tx), 32'd1);
      check("async_reset_busy", 32'(busy), 32'd0);
      check("async_reset_grant", 32'(grant), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      exp_id_q.push_back(2'd0);
      exp_data_q.push_back(4'h1);
      rst = 1'b1;
      wait_grant(c);
      req = 4'b0000;
      wait_idle();

      // ---- req 1110 held for three frames ----
      @(posedge clk); #1;
      set_payloads(4'h1, 4'h2, 4'h3, 4'h4);
      req = 4'b1110;
`ifdef SERIAL_ARB_FIXED_PRIO_EN
      exp_id_q   = '{2'd1, 2'd1, 2'd1};
      exp_data_q = '{4'h2, 4'h2, 4'h2};
`else
      exp_id_q   = '{2'd1, 2'd2, 2'd3};
      exp_data_q = '{4'h2, 4'h3, 4'h4};
`endif
      for (int g = 0; g < 3; g++) wait_grant(stamp[g]);
      req = 4'b0000;
      check("prio_spacing", 32'(stamp[2] - stamp[1]), 32'd7);
      wait_idle();

      // ---- GAP_CYCLES=0: start bit directly after stop bit ----
      @(posedge clk); #1;
      g0_payload = {4'h0, 4'h0, 4'h0, 4'b0110};
      g0_req     = 4'b0001;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         g0_tx_seq[i]   = g0_tx;
         g0_busy_seq[i] = g0_busy;
         g0_gnt_seq[i]  = g0_grant[0];
         if (i == 7) g0_req = 4'b0000;
      end
      check("gap0_tx_seq", 32'(g0_tx_seq), 32'(14'b11011001011001));
      check("gap0_busy_seq", 32'(g0_busy_seq), 32'(14'b01111111111110));
      check("gap0_grant_seq", 32'(g0_gnt_seq), 32'(14'b00000010000010));

      // ---- drain ----
      repeat (10) @(negedge clk);
      check("grant_q_empty", 32'(exp_id_q.size()), 32'd0);
      check("data_q_empty", 32'(exp_data_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
